// File: rtl/siggen_pkg.sv
// siggen_pkg: shared state encoding and default sizes for the signature generator
package siggen_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} mata_state_t;
  localparam int MATA_ADDR_W = 9;
  localparam int MATA_DAT_W  = 2100;
  localparam int MATA_ROWS   = 500;
endpackage

// File: rtl/gf2_dot.sv
// gf2_dot: registered GF(2) dot product (AND + XOR-reduce), one cycle latency
module gf2_dot #(
  parameter int W = 2100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         p
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= 1'b0;
    else if (en) p <= ^(a & b);
endmodule

// File: rtl/matvec_a_ctrl.sv
// matvec_a_ctrl: streams matrix-A ROM rows and computes y = A*x over GF(2)
module matvec_a_ctrl
  import siggen_pkg::*;
#(
  parameter int ADDR_W  = MATA_ADDR_W,
  parameter int DAT_W   = MATA_DAT_W,
  parameter int ROWS    = MATA_ROWS,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DAT_W-1:0]  x,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DAT_W-1:0]  rom_dout,
  output logic              y_valid,
  output logic              y_bit,
  output logic [ADDR_W-1:0] y_idx,
  output logic [ROWS-1:0]   y
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);
  mata_state_t state, state_nx;
  logic [DAT_W-1:0] x_q;
  logic [ROM_LAT-1:0] vld;
  logic [ADDR_W-1:0] idx_p [ROM_LAT];
  logic go, row_out;
  assign go = state == IDLE && start && !abort;
  assign row_out = vld[ROM_LAT-1] && !abort;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (state == IDLE) state_nx = start ? ISSUE : IDLE;
    else if (state == ISSUE) state_nx = rom_addr == LAST ? DRAIN : ISSUE;
    else state_nx = done ? IDLE : DRAIN;
  end
  // vld/idx_p line up each issued address with its ROM data ROM_LAT cycles later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) idx_p[i] <= '0;
      rom_addr <= '0;
      x_q <= '0;
      y_valid <= 1'b0;
      y_idx <= '0;
      done <= 1'b0;
      y <= '0;
    end else begin
      vld <= abort ? '0 : (vld << 1) | ROM_LAT'(state == ISSUE);
      for (int i = ROM_LAT - 1; i > 0; i--) idx_p[i] <= idx_p[i-1];
      idx_p[0] <= rom_addr;
      if (go) begin
        x_q <= x;
        rom_addr <= '0;
      end else if (state == ISSUE && !abort && rom_addr != LAST) rom_addr <= rom_addr + 1'b1;
      y_valid <= row_out;
      done <= row_out && idx_p[ROM_LAT-1] == LAST;
      if (row_out) y_idx <= idx_p[ROM_LAT-1];
      if (go) y <= '0;
      else if (y_valid) y[y_idx] <= y_bit;
    end
  gf2_dot #(.W(DAT_W)) u_dot (
    .clk(clk), .rst_n(rst_n), .en(row_out), .a(rom_dout), .b(x_q), .p(y_bit)
  );
endmodule

// File: tb/tb_matvec_a_ctrl.sv
// tb_matvec_a_ctrl: vector table plus randomized runs against a GF(2) reference model
module tb_matvec_a_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DUT A: default sizes, ROM_LAT=1
  logic start_a = 0, abort_a = 0, busy_a, done_a, yv_a, yb_a;
  logic [2099:0] xa = '0, dout_a;
  logic [8:0] addr_a, yi_a;
  logic [499:0] y_a;
  int mode_a = 0;
  matvec_a_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .x(xa), .busy(busy_a),
    .done(done_a), .rom_addr(addr_a), .rom_dout(dout_a), .y_valid(yv_a), .y_bit(yb_a),
    .y_idx(yi_a), .y(y_a)
  );
  function automatic logic [2099:0] row_a(input int m, input int r);
    logic [2099:0] v;
    v = (m == 1) ? '1 : '0;
    if (m == 0) v[r] = 1'b1;
    return v;
  endfunction
  function automatic logic [499:0] model_a(input int m, input logic [2099:0] xv);
    logic [499:0] e;
    for (int r = 0; r < 500; r++) e[r] = ^(row_a(m, r) & xv);
    return e;
  endfunction
  always @(posedge clk) dout_a <= row_a(mode_a, int'(addr_a));

  // DUT B: ROWS=1, ROM_LAT=3
  logic start_b = 0, abort_b = 0, busy_b, done_b, yv_b, yb_b;
  logic [15:0] xb = '0, dout_b;
  logic [3:0] addr_b, yi_b, pb1, pb2;
  logic [0:0] y_b;
  matvec_a_ctrl #(.ADDR_W(4), .DAT_W(16), .ROWS(1), .ROM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .x(xb), .busy(busy_b),
    .done(done_b), .rom_addr(addr_b), .rom_dout(dout_b), .y_valid(yv_b), .y_bit(yb_b),
    .y_idx(yi_b), .y(y_b)
  );
  always @(posedge clk) begin
    pb1 <= addr_b;
    pb2 <= pb1;
    dout_b <= (pb2 == 0) ? 16'hFFFF : 16'h0000;
  end

  // DUT C: ROWS=2^ADDR_W, ROM_LAT=2, random ROM contents
  logic start_c = 0, abort_c = 0, busy_c, done_c, yv_c, yb_c;
  logic [15:0] xc = '0, dout_c;
  logic [15:0] rom_c [8];
  logic [2:0] addr_c, yi_c, pc1;
  logic [7:0] y_c;
  matvec_a_ctrl #(.ADDR_W(3), .DAT_W(16), .ROWS(8), .ROM_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .x(xc), .busy(busy_c),
    .done(done_c), .rom_addr(addr_c), .rom_dout(dout_c), .y_valid(yv_c), .y_bit(yb_c),
    .y_idx(yi_c), .y(y_c)
  );
  always @(posedge clk) begin
    pc1 <= addr_c;
    dout_c <= rom_c[pc1];
  end

  typedef struct {
    int mode;
    logic [2099:0] x0;
    logic [2099:0] x1;
    bit mid;
    logic [499:0] ey;
    int edone;
  } vec_t;
  vec_t tab [3];

  task automatic run_a(input vec_t v);
    int t0, c, nv, bad, badaddr, dc, lowc, nd;
    nv = 0; bad = 0; badaddr = 0; dc = -1; lowc = -1; nd = 0;
    mode_a = v.mode;
    @(negedge clk);
    start_a = 1; xa = v.x0; t0 = tick;
    @(negedge clk);
    start_a = 0;
    for (int k = 0; k < 700 && lowc < 0; k++) begin
      c = tick - t0;
      if (v.mid && c == 200) xa = v.x1;
      if (c <= 500 && int'(addr_a) != c - 1) badaddr++;
      if (yv_a) begin
        nv++;
        if (int'(yi_a) != c - 3 || yb_a !== v.ey[yi_a]) bad++;
      end
      if (done_a) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (!busy_a) lowc = c;
      else @(negedge clk);
    end
    chk("a_done_cycle", dc, v.edone);
    chk("a_busy_low_cycle", lowc, v.edone + 1);
    chk("a_done_count", nd, 1);
    chk("a_valid_count", nv, 500);
    chk("a_bit_errors", bad, 0);
    chk("a_addr_errors", badaddr, 0);
    chk("a_y", y_a, v.ey);
  endtask

  task automatic run_c();
    logic [15:0] x0;
    logic [7:0] ey;
    int t0, c, nv, bad, badaddr, dc, lowc, ea;
    nv = 0; bad = 0; badaddr = 0; dc = -1; lowc = -1;
    for (int r = 0; r < 8; r++) rom_c[r] = 16'($urandom);
    x0 = 16'($urandom);
    for (int r = 0; r < 8; r++) ey[r] = ^(rom_c[r] & x0);
    start_c = 1; xc = x0; t0 = tick;
    @(negedge clk);
    start_c = 0;
    for (int k = 0; k < 40 && lowc < 0; k++) begin
      c = tick - t0;
      if (c == 3) xc = 16'($urandom);
      ea = (c <= 8) ? c - 1 : 7;
      if (int'(addr_c) != ea) badaddr++;
      if (yv_c) begin
        nv++;
        if (int'(yi_c) != c - 4 || yb_c !== ey[yi_c]) bad++;
      end
      if (done_c && dc < 0) dc = c;
      if (!busy_c) lowc = c;
      else @(negedge clk);
    end
    chk("c_done_cycle", dc, 11);
    chk("c_busy_low_cycle", lowc, 12);
    chk("c_valid_count", nv, 8);
    chk("c_bit_errors", bad, 0);
    chk("c_addr_errors", badaddr, 0);
    chk("c_y", y_c, ey);
  endtask

  initial begin
    int t0, c, nv, vc, dc, lowc, nd;
    logic vb, eb;
    logic [3:0] vi;
    logic [499:0] m48;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_y_valid", yv_a, 0);
    chk("rst_y_bit", yb_a, 0);
    chk("rst_y_idx", yi_a, 0);
    chk("rst_rom_addr", addr_a, 0);
    chk("rst_y", y_a, 0);
    rst_n = 1;

    tab[0].mode = 0; tab[0].x0 = '1; tab[0].x1 = '0; tab[0].mid = 0; tab[0].edone = 502;
    tab[1].mode = 0; tab[1].x0 = '0; tab[1].x0[7] = 1'b1; tab[1].x1 = '0; tab[1].mid = 0; tab[1].edone = 502;
    tab[2].mode = 1; tab[2].x0 = '0; tab[2].x0[3] = 1'b1; tab[2].x0[1000] = 1'b1; tab[2].x0[2099] = 1'b1;
    tab[2].x1 = '0; tab[2].x1[5] = 1'b1; tab[2].x1[6] = 1'b1; tab[2].mid = 1; tab[2].edone = 502;
    for (int i = 0; i < 3; i++) tab[i].ey = model_a(tab[i].mode, tab[i].x0);

    // reset in the middle of a product
    mode_a = 0;
    @(negedge clk);
    start_a = 1; xa = '1;
    @(negedge clk);
    start_a = 0;
    for (int k = 0; k < 200 && addr_a != 9'd100; k++) @(negedge clk);
    chk("mid_reset_reached_row100", addr_a, 100);
    #2 rst_n = 0;
    #1;
    chk("mid_reset_busy", busy_a, 0);
    chk("mid_reset_done", done_a, 0);
    chk("mid_reset_y_valid", yv_a, 0);
    chk("mid_reset_y_bit", yb_a, 0);
    chk("mid_reset_y_idx", yi_a, 0);
    chk("mid_reset_rom_addr", addr_a, 0);
    chk("mid_reset_y", y_a, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_busy", busy_a, 0);

    for (int i = 0; i < 3; i++) run_a(tab[i]);

    // abort at cycle 50
    mode_a = 0;
    @(negedge clk);
    start_a = 1; xa = '1; t0 = tick;
    @(negedge clk);
    start_a = 0;
    for (int k = 0; k < 100 && tick - t0 < 50; k++) @(negedge clk);
    abort_a = 1;
    @(negedge clk);
    abort_a = 0;
    m48 = '0;
    for (int r = 0; r < 48; r++) m48[r] = 1'b1;
    chk("abort_cycle", tick - t0, 51);
    chk("abort_y_valid", yv_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_y_partial", y_a, m48);
    run_a(tab[0]);

    // start and abort together in IDLE
    @(negedge clk);
    start_a = 1; abort_a = 1;
    @(negedge clk);
    start_a = 0; abort_a = 0;
    chk("start_abort_busy", busy_a, 0);
    @(negedge clk);
    chk("start_abort_busy_later", busy_a, 0);

    // ROWS=1, ROM_LAT=3 with a start pulse while busy
    nv = 0; vc = -1; dc = -1; lowc = -1; nd = 0; vb = 0; vi = '1;
    @(negedge clk);
    start_b = 1; xb = 16'($urandom); eb = ^xb; t0 = tick;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      c = tick - t0;
      start_b = (c == 2);
      if (yv_b) begin
        nv++; vc = c; vb = yb_b; vi = yi_b;
      end
      if (done_b) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (!busy_b && lowc < 0) lowc = c;
      @(negedge clk);
    end
    start_b = 0;
    chk("b_valid_count", nv, 1);
    chk("b_valid_cycle", vc, 5);
    chk("b_bit", vb, eb);
    chk("b_idx", vi, 0);
    chk("b_done_cycle", dc, 5);
    chk("b_done_count", nd, 1);
    chk("b_busy_low_cycle", lowc, 6);
    chk("b_y", y_b, eb);

    // back-to-back randomized products on the full-address-range instance
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_c();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
